ep0_desc_streamer: RTL and testbench
====================================

Name: ep0_desc_streamer

Overview:
Control-transfer data-stage source for GET_DESCRIPTOR on endpoint 0.
- Sits between the EP0 request decoder and the EP0 descriptor ROM.
- On a decoded request, it looks up the descriptor start address in the ROM's start-index LUT and, for configuration descriptors, reads the total length.
- It then streams min(descriptor length, wLength) bytes as MAX_PACKET_SIZE-byte IN packets to the packet serializer, with retry on a lost ACK and a terminating zero-length packet (ZLP) when one is required.

Parameters:
- ROM_IDX_WID, 8, width of the ROM address and of each LUT entry.
- NUM_CONFIGS, 1, number of configuration descriptors (bNumConfigurations).
- NUM_STR_DESCS, 3, string descriptors after string zero; 0 means no strings.
- MAX_PACKET_SIZE, 8, EP0 bMaxPacketSize0 (8/16/32/64).
- LUT_WID, ROM_IDX_WID*(NUM_CONFIGS+1+NUM_STR_DESCS), width of the start-index LUT bus.

Ports:
- clk12_i  in  1  12 MHz USB clock.
- rst_i  in  1  synchronous reset, active-high.
- reqValid_i  in  1  one-cycle pulse: GET_DESCRIPTOR decoded.
- reqDescType_i  in  8  wValue high byte: 1 = DEVICE, 2 = CONFIGURATION, 3 = STRING.
- reqDescIdx_i  in  8  wValue low byte.
- reqLength_i  in  16  wLength.
- abort_i  in  1  new SETUP received or bus reset; drop the transfer.
- descStartIdx_i  in  LUT_WID  ROM start-index LUT. Entry k is at [k*ROM_IDX_WID +: ROM_IDX_WID]. Entries 0..NUM_CONFIGS-1 are the configurations, entry NUM_CONFIGS is string zero, entry NUM_CONFIGS+1+s is string s. The device descriptor is fixed at address 0.
- romAddr_o  out  ROM_IDX_WID  ROM read address (combinational read).
- romData_i  in  8  ROM data for romAddr_o, valid in the same cycle.
- data_o  out  8  stream byte.
- dataValid_o  out  1  data_o valid.
- dataReady_i  in  1  sink consumes the byte when dataValid_o && dataReady_i.
- packetLast_o  out  1  qualifies data_o as the last byte of the current packet.
- zlp_o  out  1  a zero-length packet is to be sent.
- nextPacket_i  in  1  pulse: host ACKed the current packet.
- retry_i  in  1  pulse: ACK lost; resend the current packet.
- busy_o  out  1  transfer in progress.
- stall_o  out  1  one-cycle pulse: request unsupported, endpoint must STALL.
- done_o  out  1  one-cycle pulse: the last packet (data or ZLP) was ACKed.

Behaviour:
- Reset values: all outputs 0; state IDLE; pointers, counters and romAddr_o 0.
- State machine: IDLE, LEN0, LEN_LO, LEN_HI, STREAM, WAIT_ACK, ZLP.
  - busy_o = (state != IDLE).
  - romAddr_o is driven from a registered pointer.
- IDLE:
  - reqValid_i is latched in cycle N.
  - Unsupported request: type not in {1,2,3}, config index >= NUM_CONFIGS, string index > NUM_STR_DESCS, or type 3 with NUM_STR_DESCS = 0.
    - Pulse stall_o in N+1, remain IDLE.
  - reqLength_i = 0: pulse done_o in N+1, remain IDLE.
  - Otherwise enter LEN0 with pointer = start address.
  - String index i selects LUT entry NUM_CONFIGS+i: string zero for i = 0, string i-1 for i >= 1.
- LEN0:
  - Latch descLen = romData_i (bLength).
  - Device/string: go to STREAM.
  - Configuration: go to LEN_LO (address start+2), then LEN_HI (address start+3), forming descLen = {byte3, byte2} (wTotalLength). Then go to STREAM with pointer = start.
- Transfer setup:
  - remaining = min(descLen, reqLength_i), 16-bit unsigned.
  - needZlp = (remaining < reqLength_i) && (remaining % MAX_PACKET_SIZE == 0).
- Latency: first dataValid_o in N+2 (device/string) or N+4 (configuration).
- STREAM:
  - data_o = romData_i; dataValid_o = 1.
  - packetLast_o = (pktCnt == MAX_PACKET_SIZE-1) || (remaining == 1).
  - On a handshake: pointer+1, remaining-1, pktCnt+1.
  - With dataValid_o && !dataReady_i, data_o is held stable.
  - After the handshake on a packetLast_o byte: go to WAIT_ACK with dataValid_o = 0.
  - At packet start, snapshot pktStartPtr and pktStartRemaining.
- WAIT_ACK:
  - retry_i: restore the pointer and remaining from the snapshot, pktCnt = 0, go to STREAM.
  - nextPacket_i with remaining > 0: pktCnt = 0, go to STREAM.
  - nextPacket_i with remaining == 0 and needZlp: go to ZLP.
  - nextPacket_i with remaining == 0 and no ZLP needed: pulse done_o, go to IDLE.
- ZLP:
  - zlp_o = 1, dataValid_o = 0.
  - retry_i: stay in ZLP.
  - nextPacket_i: pulse done_o, go to IDLE.
- Priority, highest first: rst_i, then abort_i, then retry_i, then nextPacket_i.
  - abort_i in any state: IDLE next cycle, all outputs deasserted, no done_o pulse.
  - If retry_i and nextPacket_i arrive together, retry_i wins.
  - retry_i or nextPacket_i while in STREAM/LEN*: ignored.
  - reqValid_i while busy_o: ignored; abort_i must come first. If abort_i and reqValid_i arrive together, abort_i wins and the request is dropped.
- The pointer wraps modulo 2^ROM_IDX_WID with no check; the ROM builder guarantees every descriptor lies in range.

Test Plan:
- DEVICE (bLength 18), wLength 64, MPS 8 -> packets of 8, 8, 2 bytes, each ACKed; no ZLP; done_o after the 3rd nextPacket_i. First byte 0x12 at N+2.
- DEVICE, wLength 8 -> one 8-byte packet (bytes 0..7) with packetLast_o on byte 7; done_o after its ACK.
- CONFIGURATION 0 with wTotalLength 32, wLength 255, MPS 8 -> first byte at N+4; 4 packets of 8 bytes, then zlp_o asserted; done_o after the 5th ACK.
- STRING index 5 with NUM_STR_DESCS 3, and type 6 -> stall_o pulse in N+1, busy_o stays 0. wLength 0 on DEVICE -> done_o pulse, no data.
- Second packet of DEVICE: dataReady_i toggled 1/0 every cycle, then retry_i in WAIT_ACK -> the identical bytes 8..15 are retransmitted and data_o is stable during stalls. retry_i+nextPacket_i in the same cycle -> retransmit.
- abort_i mid-STREAM on the 3rd byte -> IDLE next cycle, dataValid_o 0, no done_o. A new request is then accepted normally.

Source files
------------

// File: rtl/ep0_desc_streamer.sv
// EP0 GET_DESCRIPTOR data-stage source: resolves the descriptor in the ROM,
// then streams min(length, wLength) bytes as MPS-sized IN packets with retry and ZLP.
module ep0_desc_streamer #(
   parameter int ROM_IDX_WID     = 8,
   parameter int NUM_CONFIGS     = 1,
   parameter int NUM_STR_DESCS   = 3,
   parameter int MAX_PACKET_SIZE = 8,
   parameter int LUT_WID         = ROM_IDX_WID*(NUM_CONFIGS+1+NUM_STR_DESCS)
) (
   input  logic                   clk12_i,
   input  logic                   rst_i,
   input  logic                   reqValid_i,
   input  logic [7:0]             reqDescType_i,
   input  logic [7:0]             reqDescIdx_i,
   input  logic [15:0]            reqLength_i,
   input  logic                   abort_i,
   input  logic [LUT_WID-1:0]     descStartIdx_i,
   output logic [ROM_IDX_WID-1:0] romAddr_o,
   input  logic [7:0]             romData_i,
   output logic [7:0]             data_o,
   output logic                   dataValid_o,
   input  logic                   dataReady_i,
   output logic                   packetLast_o,
   output logic                   zlp_o,
   input  logic                   nextPacket_i,
   input  logic                   retry_i,
   output logic                   busy_o,
   output logic                   stall_o,
   output logic                   done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN_LO, S_LEN_HI, S_STREAM, S_WAIT_ACK, S_ZLP
   } state_t;

   localparam logic [15:0] MPS16  = 16'(MAX_PACKET_SIZE);
   localparam logic [7:0]  MPS_M1 = 8'(MAX_PACKET_SIZE-1);

   function automatic logic [15:0] min_len(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic zlp_needed(input logic [15:0] rem, input logic [15:0] req);
      return (rem < req) && ((rem % MPS16) == 16'd0);
   endfunction

   state_t                 state_q, state_d;
   logic [ROM_IDX_WID-1:0] ptr_q, ptr_d;
   logic [ROM_IDX_WID-1:0] start_q, start_d;
   logic [ROM_IDX_WID-1:0] snap_ptr_q, snap_ptr_d;
   logic [7:0]             desc_lo_q, desc_lo_d;
   logic [15:0]            req_len_q, req_len_d;
   logic [15:0]            remaining_q, remaining_d;
   logic [15:0]            snap_rem_q, snap_rem_d;
   logic [7:0]             pkt_cnt_q, pkt_cnt_d;
   logic                   need_zlp_q, need_zlp_d;
   logic                   is_cfg_q, is_cfg_d;
   logic                   stall_q, stall_d;
   logic                   done_q, done_d;

   logic                   req_unsup;
   int                     lut_k;
   logic [ROM_IDX_WID-1:0] req_start;
   logic [15:0]            setup_len;
   logic [15:0]            setup_rem;
   logic                   begin_xfer;
   logic                   pkt_last;

   // Request decode: pick the LUT entry, the device descriptor lives at address 0
   always_comb begin
      req_unsup = 1'b0;
      lut_k     = 0;
      case (reqDescType_i)
         8'd1: req_unsup = 1'b0;
         8'd2: begin
            if (int'(reqDescIdx_i) >= NUM_CONFIGS) req_unsup = 1'b1;
            else                                   lut_k     = int'(reqDescIdx_i);
         end
         8'd3: begin
            if (NUM_STR_DESCS == 0 || int'(reqDescIdx_i) > NUM_STR_DESCS) req_unsup = 1'b1;
            else                                                          lut_k     = NUM_CONFIGS + int'(reqDescIdx_i);
         end
         default: req_unsup = 1'b1;
      endcase
      req_start = (reqDescType_i == 8'd1) ? '0
                                           : descStartIdx_i[lut_k*ROM_IDX_WID +: ROM_IDX_WID];
   end

   assign setup_len = (state_q == S_LEN_HI) ? {romData_i, desc_lo_q} : {8'h00, romData_i};
   assign setup_rem = min_len(setup_len, req_len_q);
   assign pkt_last  = (pkt_cnt_q == MPS_M1) || (remaining_q == 16'd1);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      start_d     = start_q;
      snap_ptr_d  = snap_ptr_q;
      desc_lo_d   = desc_lo_q;
      req_len_d   = req_len_q;
      remaining_d = remaining_q;
      snap_rem_d  = snap_rem_q;
      pkt_cnt_d   = pkt_cnt_q;
      need_zlp_d  = need_zlp_q;
      is_cfg_d    = is_cfg_q;
      stall_d     = 1'b0;
      done_d      = 1'b0;
      begin_xfer  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (reqValid_i) begin
               if (req_unsup) begin
                  stall_d = 1'b1;
               end else if (reqLength_i == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = S_LEN0;
                  ptr_d     = req_start;
                  start_d   = req_start;
                  req_len_d = reqLength_i;
                  is_cfg_d  = (reqDescType_i == 8'd2);
               end
            end
         end
         S_LEN0: begin
            desc_lo_d = romData_i;
            if (is_cfg_q) begin
               state_d = S_LEN_LO;
               ptr_d   = start_q + ROM_IDX_WID'(2);
            end else begin
               begin_xfer = 1'b1;
            end
         end
         S_LEN_LO: begin
            desc_lo_d = romData_i;
            ptr_d     = ptr_q + ROM_IDX_WID'(1);
            state_d   = S_LEN_HI;
         end
         S_LEN_HI: begin
            begin_xfer = 1'b1;
         end
         S_STREAM: begin
            if (dataReady_i) begin
               ptr_d       = ptr_q + ROM_IDX_WID'(1);
               remaining_d = remaining_q - 16'd1;
               pkt_cnt_d   = pkt_cnt_q + 8'd1;
               if (pkt_last) state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (retry_i) begin
               ptr_d       = snap_ptr_q;
               remaining_d = snap_rem_q;
               pkt_cnt_d   = 8'd0;
               state_d     = S_STREAM;
            end else if (nextPacket_i) begin
               if (remaining_q != 16'd0) begin
                  pkt_cnt_d  = 8'd0;
                  snap_ptr_d = ptr_q;
                  snap_rem_d = remaining_q;
                  state_d    = S_STREAM;
               end else if (need_zlp_q) begin
                  state_d = S_ZLP;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_ZLP: begin
            if (nextPacket_i && !retry_i) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Length known: rewind to the descriptor start; an empty descriptor goes straight to the ZLP
      if (begin_xfer) begin
         ptr_d       = start_q;
         remaining_d = setup_rem;
         need_zlp_d  = zlp_needed(setup_rem, req_len_q);
         pkt_cnt_d   = 8'd0;
         snap_ptr_d  = start_q;
         snap_rem_d  = setup_rem;
         state_d     = (setup_rem == 16'd0) ? S_ZLP : S_STREAM;
      end

      if (abort_i) begin
         state_d = S_IDLE;
         ptr_d   = '0;
         stall_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk12_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         start_q     <= '0;
         snap_ptr_q  <= '0;
         desc_lo_q   <= 8'h00;
         req_len_q   <= 16'd0;
         remaining_q <= 16'd0;
         snap_rem_q  <= 16'd0;
         pkt_cnt_q   <= 8'd0;
         need_zlp_q  <= 1'b0;
         is_cfg_q    <= 1'b0;
         stall_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         start_q     <= start_d;
         snap_ptr_q  <= snap_ptr_d;
         desc_lo_q   <= desc_lo_d;
         req_len_q   <= req_len_d;
         remaining_q <= remaining_d;
         snap_rem_q  <= snap_rem_d;
         pkt_cnt_q   <= pkt_cnt_d;
         need_zlp_q  <= need_zlp_d;
         is_cfg_q    <= is_cfg_d;
         stall_q     <= stall_d;
         done_q      <= done_d;
      end
   end

   assign romAddr_o    = ptr_q;
   assign data_o       = (state_q == S_STREAM) ? romData_i : 8'h00;
   assign dataValid_o  = (state_q == S_STREAM);
   assign packetLast_o = (state_q == S_STREAM) && pkt_last;
   assign zlp_o        = (state_q == S_ZLP);
   assign busy_o       = (state_q != S_IDLE);
   assign stall_o      = stall_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_ep0_desc_streamer.sv
// Bench for ep0_desc_streamer: a ROM image plus a packet-level host model
// produce the expected byte stream, packet sizes, ZLP and handshake pulses.
module tb_ep0_desc_streamer;

   localparam int W   = 8;
   localparam int NC  = 1;
   localparam int NS  = 3;
   localparam int MPS = 8;
   localparam int LW  = W*(NC+1+NS);

   logic          clk = 1'b0;
   logic          rst;
   logic          reqValid;
   logic [7:0]    reqDescType;
   logic [7:0]    reqDescIdx;
   logic [15:0]   reqLength;
   logic          abort;
   logic [LW-1:0] lut_bus;
   logic [W-1:0]  romAddr;
   logic [7:0]    romData;
   logic [7:0]    data;
   logic          dataValid;
   logic          dataReady;
   logic          packetLast;
   logic          zlp;
   logic          nextPacket;
   logic          retry;
   logic          busy;
   logic          stall;
   logic          done;

   always #5 clk = ~clk;

   logic [7:0] rom [0:255];
   int         lut_entry [0:4] = '{32, 64, 80, 100, 130};
   assign romData = rom[romAddr];

   ep0_desc_streamer #(
      .ROM_IDX_WID(W), .NUM_CONFIGS(NC), .NUM_STR_DESCS(NS), .MAX_PACKET_SIZE(MPS), .LUT_WID(LW)
   ) dut (
      .clk12_i(clk), .rst_i(rst), .reqValid_i(reqValid), .reqDescType_i(reqDescType),
      .reqDescIdx_i(reqDescIdx), .reqLength_i(reqLength), .abort_i(abort),
      .descStartIdx_i(lut_bus), .romAddr_o(romAddr), .romData_i(romData), .data_o(data),
      .dataValid_o(dataValid), .dataReady_i(dataReady), .packetLast_o(packetLast), .zlp_o(zlp),
      .nextPacket_i(nextPacket), .retry_i(retry), .busy_o(busy), .stall_o(stall), .done_o(done)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_bytes[$];
   int         exp_pkt_len[$];
   bit         exp_zlp;
   bit         exp_stall;
   int         exp_done;

   logic [7:0] obs_bytes[$];
   logic [7:0] obs_retx[$];
   logic [7:0] cur_pkt[$];
   int         obs_pkt_len[$];
   bit         obs_zlp;
   int         obs_done;
   int         obs_stall;
   bit         obs_busy;
   int         obs_first;
   int         obs_unstable;

   // Host-side reference: descriptor lookup, truncation and packetisation from the ROM image
   task automatic model(input int t, input int idx, input int wlen);
      int start, len, n, left;
      exp_bytes.delete();
      exp_pkt_len.delete();
      exp_zlp   = 0;
      exp_stall = 0;
      exp_done  = 0;
      if (!(t == 1 || (t == 2 && idx < NC) || (t == 3 && NS > 0 && idx <= NS))) begin
         exp_stall = 1;
         return;
      end
      exp_done = 1;
      if (wlen == 0) return;
      start = (t == 1) ? 0 : (t == 2) ? lut_entry[idx] : lut_entry[NC+idx];
      len   = (t == 2) ? int'(rom[(start+2)%256]) + 256*int'(rom[(start+3)%256]) : int'(rom[start]);
      n     = (len < wlen) ? len : wlen;
      for (int i = 0; i < n; i++) exp_bytes.push_back(rom[(start+i)%256]);
      left = n;
      while (left > 0) begin
         exp_pkt_len.push_back((left > MPS) ? MPS : left);
         left -= MPS;
      end
      exp_zlp = (n < wlen) && (n % MPS == 0);
   endtask

   function automatic int bytes_diff();
      int d = 0;
      if (obs_bytes.size() != exp_bytes.size()) return 1000 + obs_bytes.size();
      foreach (exp_bytes[i]) if (obs_bytes[i] !== exp_bytes[i]) d++;
      return d;
   endfunction

   function automatic int pkts_diff();
      int d = 0;
      if (obs_pkt_len.size() != exp_pkt_len.size()) return 1000 + obs_pkt_len.size();
      foreach (exp_pkt_len[i]) if (obs_pkt_len[i] != exp_pkt_len[i]) d++;
      return d;
   endfunction

   function automatic int retx_diff(input int p);
      int d = 0;
      if (p >= exp_pkt_len.size() || obs_retx.size() != exp_pkt_len[p]) return 1000 + obs_retx.size();
      foreach (obs_retx[i]) if (obs_retx[i] !== exp_bytes[p*MPS+i]) d++;
      return d;
   endfunction

   // rdy_mode: 0..100 = percent ready, negative = alternate 1/0 each cycle
   task automatic run_xfer(input int t, input int idx, input int wlen, input int rdy_mode,
                           input int retry_pkt, input bit retry_both);
      int         c = 0;
      int         pkt_no = 0;
      bit         await_ack = 0;
      bit         retried = 0;
      bit         held = 0;
      bit         timeout = 0;
      logic [7:0] held_data = 8'h00;
      obs_bytes.delete(); obs_pkt_len.delete(); obs_retx.delete(); cur_pkt.delete();
      obs_zlp = 0; obs_done = 0; obs_stall = 0; obs_busy = 0; obs_first = -1; obs_unstable = 0;
      @(negedge clk);
      reqDescType = 8'(t);
      reqDescIdx  = 8'(idx);
      reqLength   = 16'(wlen);
      reqValid    = 1'b1;
      while (1) begin
         @(negedge clk);
         c++;
         reqValid   = 1'b0;
         nextPacket = 1'b0;
         retry      = 1'b0;
         if (done)  obs_done++;
         if (stall) obs_stall++;
         if (busy)  obs_busy = 1;
         dataReady = (rdy_mode < 0) ? (c % 2 == 0) : ($urandom_range(99) < rdy_mode);
         if (dataValid) begin
            if (obs_first < 0) obs_first = c;
            if (held && data !== held_data) obs_unstable++;
            if (dataReady) begin
               held = 0;
               obs_bytes.push_back(data);
               cur_pkt.push_back(data);
               if (packetLast) begin
                  obs_pkt_len.push_back(cur_pkt.size());
                  await_ack = 1;
               end
            end else begin
               held      = 1;
               held_data = data;
            end
         end else begin
            held = 0;
            if (await_ack) begin
               await_ack = 0;
               if (pkt_no == retry_pkt && !retried) begin
                  retried    = 1;
                  retry      = 1'b1;
                  nextPacket = retry_both;
                  obs_retx   = cur_pkt;
                  for (int i = 0; i < cur_pkt.size(); i++) void'(obs_bytes.pop_back());
                  void'(obs_pkt_len.pop_back());
               end else begin
                  nextPacket = 1'b1;
                  pkt_no++;
               end
               cur_pkt.delete();
            end else if (zlp) begin
               obs_zlp    = 1;
               nextPacket = 1'b1;
            end
         end
         if (c >= 3 && !busy) break;
         if (c > 3000) begin
            timeout = 1;
            break;
         end
      end
      dataReady  = 1'b0;
      nextPacket = 1'b0;
      retry      = 1'b0;
      checks++;
      if (timeout) begin
         errors++;
         $display("FAIL xfer_timeout t=%0d idx=%0d wlen=%0d cycles=%0d limit 3000", t, idx, wlen, c);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({dataValid, packetLast, zlp, busy, stall, done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=000000", {dataValid, packetLast, zlp, busy, stall, done});
      end
      checks++;
      if ({romAddr, data} !== 16'h0) begin
         errors++;
         $display("FAIL reset_addr_data got=%h want=0000", {romAddr, data});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_device_multi();
      int d;
      model(1, 0, 64);
      run_xfer(1, 0, 64, 100, -1, 0);
      d = bytes_diff(); checks++;
      if (d != 0) begin errors++; $display("FAIL dev64_bytes diff=%0d want 0", d); end
      d = pkts_diff(); checks++;
      if (d != 0) begin errors++; $display("FAIL dev64_pkts diff=%0d want 0 (8,8,2)", d); end
      checks++;
      if (obs_bytes.size() < 1 || obs_bytes[0] !== 8'h12) begin
         errors++; $display("FAIL dev64_first_byte got=%0d bytes want first 12h", obs_bytes.size());
      end
      checks++;
      if (obs_first != 2) begin errors++; $display("FAIL dev64_latency got=%0d want 2", obs_first); end
      checks++;
      if (obs_done != 1 || obs_zlp) begin
         errors++; $display("FAIL dev64_done got done=%0d zlp=%0d want 1 0", obs_done, obs_zlp);
      end
   endtask

   task automatic test_device_one_pkt();
      int d;
      model(1, 0, 8);
      run_xfer(1, 0, 8, 100, -1, 0);
      d = bytes_diff() + pkts_diff(); checks++;
      if (d != 0) begin errors++; $display("FAIL dev8_stream diff=%0d want 0", d); end
      checks++;
      if (obs_done != 1 || obs_zlp) begin
         errors++; $display("FAIL dev8_done got done=%0d zlp=%0d want 1 0", obs_done, obs_zlp);
      end
   endtask

   task automatic test_config_zlp();
      int d;
      model(2, 0, 255);
      run_xfer(2, 0, 255, 100, -1, 0);
      d = bytes_diff() + pkts_diff(); checks++;
      if (d != 0 || exp_pkt_len.size() != 4) begin
         errors++; $display("FAIL cfg_stream diff=%0d pkts=%0d want 0 and 4", d, obs_pkt_len.size());
      end
      checks++;
      if (obs_first != 4) begin errors++; $display("FAIL cfg_latency got=%0d want 4", obs_first); end
      checks++;
      if (!obs_zlp || obs_done != 1) begin
         errors++; $display("FAIL cfg_zlp got zlp=%0d done=%0d want 1 1", obs_zlp, obs_done);
      end
   endtask

   task automatic test_stall();
      run_xfer(3, 5, 20, 100, -1, 0);
      checks++;
      if (obs_stall != 1 || obs_busy || obs_done != 0) begin
         errors++; $display("FAIL stall_str5 got stall=%0d busy=%0d done=%0d want 1 0 0", obs_stall, obs_busy, obs_done);
      end
      run_xfer(6, 0, 20, 100, -1, 0);
      checks++;
      if (obs_stall != 1 || obs_busy || obs_done != 0) begin
         errors++; $display("FAIL stall_type6 got stall=%0d busy=%0d done=%0d want 1 0 0", obs_stall, obs_busy, obs_done);
      end
   endtask

   task automatic test_zero_len();
      run_xfer(1, 0, 0, 100, -1, 0);
      checks++;
      if (obs_done != 1 || obs_busy || obs_bytes.size() != 0 || obs_stall != 0) begin
         errors++; $display("FAIL zero_len got done=%0d busy=%0d bytes=%0d want 1 0 0", obs_done, obs_busy, obs_bytes.size());
      end
   endtask

   task automatic test_retry(input bit both);
      int d;
      model(1, 0, 64);
      run_xfer(1, 0, 64, -1, both ? 0 : 1, both);
      d = bytes_diff() + pkts_diff(); checks++;
      if (d != 0) begin errors++; $display("FAIL retry%0d_stream diff=%0d want 0", both, d); end
      d = retx_diff(both ? 0 : 1); checks++;
      if (d != 0) begin errors++; $display("FAIL retry%0d_first_copy diff=%0d want 0", both, d); end
      checks++;
      if (obs_unstable != 0 || obs_done != 1) begin
         errors++; $display("FAIL retry%0d_hold got unstable=%0d done=%0d want 0 1", both, obs_unstable, obs_done);
      end
   endtask

   task automatic test_abort();
      int c = 0;
      int hs = 0;
      int bad = 0;
      int d;
      @(negedge clk);
      reqDescType = 8'd1; reqDescIdx = 8'd0; reqLength = 16'd64;
      reqValid = 1'b1; dataReady = 1'b1;
      while (c < 50) begin
         @(negedge clk);
         c++;
         reqValid = 1'b0;
         if (dataValid && hs == 2) begin
            abort = 1'b1;
            break;
         end
         if (dataValid && dataReady) hs++;
      end
      checks++;
      if (c >= 50) begin errors++; $display("FAIL abort_reach_byte3 cycles=%0d limit 50", c); end
      @(negedge clk);
      abort = 1'b0; dataReady = 1'b0;
      checks++;
      if ({busy, dataValid, packetLast, zlp, done} !== 5'b0) begin
         errors++; $display("FAIL abort_idle got=%b want=00000", {busy, dataValid, packetLast, zlp, done});
      end
      repeat (5) begin
         @(negedge clk);
         if (done || busy) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL abort_no_done got=%0d want 0", bad); end
      reqValid = 1'b1; abort = 1'b1;
      @(negedge clk);
      reqValid = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, stall} !== 3'b0) begin
         errors++; $display("FAIL abort_with_req got=%b want=000", {busy, done, stall});
      end
      model(1, 0, 64);
      run_xfer(1, 0, 64, 100, -1, 0);
      d = bytes_diff() + pkts_diff(); checks++;
      if (d != 0 || obs_done != 1) begin
         errors++; $display("FAIL abort_recover diff=%0d done=%0d want 0 1", d, obs_done);
      end
   endtask

   task automatic test_random();
      int t, idx, wlen, r, rp, rm, d;
      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 9);
         if (r <= 2)      begin t = 1; idx = $urandom_range(0, 3); end
         else if (r <= 4) begin t = 2; idx = $urandom_range(0, 1); end
         else if (r <= 8) begin t = 3; idx = $urandom_range(0, 4); end
         else             begin t = $urandom_range(4, 255); idx = 0; end
         r = $urandom_range(0, 9);
         wlen = (r == 0) ? 0 : (r <= 4) ? $urandom_range(1, 20) : $urandom_range(1, 300);
         rp = int'($urandom_range(0, 4)) - 1;
         rm = $urandom_range(30, 100);
         model(t, idx, wlen);
         run_xfer(t, idx, wlen, rm, rp, 1'($urandom_range(0, 1)));
         d = bytes_diff() + pkts_diff(); checks++;
         if (d != 0) begin errors++; $display("FAIL rand%0d_stream t=%0d idx=%0d wlen=%0d diff=%0d want 0", k, t, idx, wlen, d); end
         checks++;
         if (obs_zlp != exp_zlp || obs_done != exp_done || obs_stall != int'(exp_stall) || obs_unstable != 0) begin
            errors++;
            $display("FAIL rand%0d_ctrl got zlp=%0d done=%0d stall=%0d unstable=%0d want %0d %0d %0d 0",
                     k, obs_zlp, obs_done, obs_stall, obs_unstable, exp_zlp, exp_done, exp_stall);
         end
         if (obs_retx.size() > 0) begin
            d = retx_diff(rp); checks++;
            if (d != 0) begin errors++; $display("FAIL rand%0d_retx diff=%0d want 0", k, d); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; reqValid = 1'b0; reqDescType = 8'd0; reqDescIdx = 8'd0; reqLength = 16'd0;
      abort = 1'b0; dataReady = 1'b0; nextPacket = 1'b0; retry = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[0]  = 8'd18; rom[1]  = 8'd1;
      rom[32] = 8'd9;  rom[33] = 8'd2; rom[34] = 8'd32; rom[35] = 8'd0;
      rom[64] = 8'd4;  rom[65] = 8'd3;
      rom[80] = 8'd10; rom[100] = 8'd16; rom[130] = 8'd7;
      for (int k = 0; k < 5; k++) lut_bus[k*W +: W] = 8'(lut_entry[k]);

      test_reset();
      test_device_multi();
      test_device_one_pkt();
      test_config_zlp();
      test_stall();
      test_zero_len();
      test_retry(1'b0);
      test_retry(1'b1);
      test_abort();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
